mux_scan_ctrl: RTL and testbench

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

---
 rtl/mux_scan_ctrl.sv | 89 ++++++++
 tb/tb_mux_scan_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - sequencer that scans a 4-to-1 pass-transistor mux
// and publishes each completed 4-channel sample as a single atomic DATA word.
module mux_scan_ctrl #(
  parameter int SETTLE_CYC = 2
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       START,
  input  logic       CONT,
  input  logic       MUXOUT,
  output logic       S1,
  output logic       S2,
  output logic [3:0] DATA,
  output logic       VALID,
  output logic       BUSY
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYC - 1);

  logic [0:0] state;
  logic [1:0] ch;
  logic [3:0] cnt;
  logic [3:0] shadow;
  logic [1:0] ch_nxt;
  logic       sample_now;
  logic       scan_done;

  assign ch_nxt     = ch + 2'd1;
  assign sample_now = (state == ST_SCAN) && (cnt == LAST_CNT);
  assign scan_done  = sample_now && (ch == 2'd3);

  // Channel n drives select code ~n, so {S2,S1} runs 11,10,01,00 for A..D and
  // the shadow bit for channel n is bit ~n (A lands in bit3).
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state  <= ST_IDLE;
      ch     <= 2'd0;
      cnt    <= 4'd0;
      shadow <= 4'd0;
      S1     <= 1'b0;
      S2     <= 1'b0;
      DATA   <= 4'd0;
      VALID  <= 1'b0;
      BUSY   <= 1'b0;
    end else begin
      VALID <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START) begin
            state    <= ST_SCAN;
            ch       <= 2'd0;
            cnt      <= 4'd0;
            shadow   <= 4'd0;
            {S2, S1} <= 2'b11;
            BUSY     <= 1'b1;
          end
        end
        default: begin
          if (sample_now) begin
            shadow[~ch] <= MUXOUT;
            cnt         <= 4'd0;
            if (scan_done) begin
              // ch3 is captured on this same edge, so bypass the shadow for it.
              DATA  <= {shadow[3:1], MUXOUT};
              VALID <= 1'b1;
              ch    <= 2'd0;
              if (CONT) begin
                {S2, S1} <= 2'b11;
              end else begin
                state    <= ST_IDLE;
                {S2, S1} <= 2'b00;
                BUSY     <= 1'b0;
              end
            end else begin
              ch       <= ch_nxt;
              {S2, S1} <= ~ch_nxt;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - directed self-checking bench for mux_scan_ctrl
// with SETTLE_CYC=2 and SETTLE_CYC=1 instances sharing one clock.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       cont;
  logic       start, start_f;
  logic [3:0] chans, chans_f;   // bit3=A .. bit0=D
  logic       muxout, muxout_f;
  logic       s1, s2, s1_f, s2_f;
  logic [3:0] data, data_f;
  logic       valid, valid_f, busy, busy_f;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  assign muxout   = s2   ? (s1   ? chans[3]   : chans[2])   : (s1   ? chans[1]   : chans[0]);
  assign muxout_f = s2_f ? (s1_f ? chans_f[3] : chans_f[2]) : (s1_f ? chans_f[1] : chans_f[0]);

  mux_scan_ctrl #(.SETTLE_CYC(2)) u_dut (
    .CLK(clk), .RSTn(rstn), .START(start), .CONT(cont), .MUXOUT(muxout),
    .S1(s1), .S2(s2), .DATA(data), .VALID(valid), .BUSY(busy)
  );

  mux_scan_ctrl #(.SETTLE_CYC(1)) u_fast (
    .CLK(clk), .RSTn(rstn), .START(start_f), .CONT(1'b0), .MUXOUT(muxout_f),
    .S1(s1_f), .S2(s2_f), .DATA(data_f), .VALID(valid_f), .BUSY(busy_f)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 0; start_f = 0; cont = 0; chans = 4'b1010; chans_f = 4'b0;
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    start = 1; tick(); start = 0;
    repeat (3) tick();
    total++;
    if ({s2, s1} !== 2'b10) $display("FAIL pre_reset_sel: got %b expected 10", {s2, s1});
    else passed++;
    #3 rstn = 1'b0;
    #1;
    total++;
    if ({s2, s1, busy, valid, data} !== 8'b0) $display("FAIL async_reset: got s2s1=%b busy=%b valid=%b data=%b expected all 0", {s2, s1}, busy, valid, data);
    else passed++;
    total++;
    if ({s2_f, s1_f, busy_f, valid_f, data_f} !== 8'b0) $display("FAIL async_reset_fast: got %b expected 0", {s2_f, s1_f, busy_f, valid_f, data_f});
    else passed++;
    tick();
    #2 rstn = 1'b1;
    start = 1;
    tick();
    start = 0;
    total++;
    if ({busy, s2, s1} !== 3'b111) $display("FAIL first_edge_after_reset: got busy,s2s1=%b expected 111", {busy, s2, s1});
    else passed++;
    repeat (8) tick();
    total++;
    if ({valid, data} !== 5'b1_1010) $display("FAIL post_reset_scan: got valid=%b data=%b expected 1 1010", valid, data);
    else passed++;
    tick();
  endtask

  task automatic test_single();
    logic [1:0] exp_sel;
    int bad = 0;
    chans = 4'b1010;
    start = 1; tick(); start = 0;
    for (int e = 0; e < 8; e++) begin
      exp_sel = 2'(3 - e / 2);
      if ({s2, s1} !== exp_sel || busy !== 1'b1 || valid !== 1'b0) begin
        $display("FAIL single_sel edge %0d: got s2s1=%b busy=%b valid=%b expected %b 1 0", e, {s2, s1}, busy, valid, exp_sel);
        bad++;
      end
      tick();
    end
    total++;
    if (bad == 0) passed++;
    total++;
    if ({data, valid, busy, s2, s1} !== 8'b1010_1000) $display("FAIL single_done: got data=%b valid=%b busy=%b s2s1=%b expected 1010 1 0 00", data, valid, busy, {s2, s1});
    else passed++;
    tick();
    total++;
    if ({valid, data} !== 5'b0_1010) $display("FAIL single_valid_pulse: got valid=%b data=%b expected 0 1010", valid, data);
    else passed++;
  endtask

  task automatic test_start_ignored();
    int nvalid = 0;
    int vedge = -1;
    chans = 4'b0101;
    start = 1; tick(); start = 0;
    for (int e = 1; e <= 20; e++) begin
      if (e == 3) start = 1;
      tick();
      start = 0;
      if (valid) begin nvalid++; vedge = e; end
    end
    total++;
    if (nvalid != 1 || vedge != 8) $display("FAIL start_ignored: got %0d valids last at edge %0d expected 1 at edge 8", nvalid, vedge);
    else passed++;
    total++;
    if ({data, busy} !== 5'b0101_0) $display("FAIL start_ignored_data: got data=%b busy=%b expected 0101 0", data, busy);
    else passed++;
  endtask

  task automatic test_continuous();
    int nvalid = 0;
    int bad = 0;
    chans = 4'b0110;
    cont = 1;
    start = 1; tick(); start = 0;
    for (int e = 1; e <= 30; e++) begin
      tick();
      if (e == 20) cont = 0;
      if (valid) begin
        nvalid++;
        if (e != 8 * nvalid || data !== 4'b0110) begin
          $display("FAIL cont_valid: got edge %0d data=%b expected edge %0d data 0110", e, data, 8 * nvalid);
          bad++;
        end
      end
      if (e < 24 && busy !== 1'b1) begin
        $display("FAIL cont_busy edge %0d: got %b expected 1", e, busy);
        bad++;
      end
    end
    total++;
    if (bad == 0) passed++;
    total++;
    if (nvalid != 3 || busy !== 1'b0) $display("FAIL cont_stop: got %0d valids busy=%b expected 3 0", nvalid, busy);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int nvalid = 0;
    int bad = 0;
    chans = 4'b1001;
    start = 1; tick(); start = 0;
    repeat (5) tick();
    #2 rstn = 1'b0;
    #1;
    total++;
    if ({busy, s2, s1, data} !== 7'b0) $display("FAIL mid_reset: got busy=%b s2s1=%b data=%b expected 0 00 0000", busy, {s2, s1}, data);
    else passed++;
    #1 rstn = 1'b1;
    for (int e = 6; e <= 18; e++) begin
      if (e == 10) start = 1;
      tick();
      start = 0;
      if (valid) nvalid++;
      if (e < 18 && data !== 4'b0000) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL mid_reset_data_hold: got %0d edges with data!=0 expected 0", bad);
    else passed++;
    total++;
    if (nvalid != 1 || {valid, data} !== 5'b1_1001) $display("FAIL mid_reset_rescan: got %0d valids valid=%b data=%b expected 1 1 1001", nvalid, valid, data);
    else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    int nvalid = 0;
    int bad = 0;
    chans = 4'b1100;
    start = 1;
    tick();
    for (int e = 1; e <= 17; e++) begin
      tick();
      if (valid) begin
        nvalid++;
        if (e != 8 && e != 17) bad++;
      end
      if (e == 8 && busy !== 1'b0) bad++;
      if (e == 9 && {busy, s2, s1} !== 3'b111) bad++;
    end
    start = 0;
    total++;
    if (bad != 0 || nvalid != 2 || data !== 4'b1100) $display("FAIL back_to_back: got %0d valids %0d errs data=%b expected 2 0 1100", nvalid, bad, data);
    else passed++;
    repeat (10) tick();
  endtask

  task automatic test_settle1();
    int bad = 0;
    chans_f = 4'b1111;
    start_f = 1; tick(); start_f = 0;
    for (int e = 0; e < 4; e++) begin
      if ({s2_f, s1_f} !== 2'(3 - e) || busy_f !== 1'b1 || valid_f !== 1'b0) begin
        $display("FAIL settle1_sel edge %0d: got s2s1=%b busy=%b expected %0d 1", e, {s2_f, s1_f}, busy_f, 3 - e);
        bad++;
      end
      tick();
    end
    total++;
    if (bad == 0) passed++;
    total++;
    if ({data_f, valid_f, busy_f} !== 6'b1111_10) $display("FAIL settle1_done: got data=%b valid=%b busy=%b expected 1111 1 0", data_f, valid_f, busy_f);
    else passed++;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_start_ignored();
    test_continuous();
    test_reset_mid();
    test_back_to_back();
    test_settle1();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
